// File: rtl/deflect_alloc_sched_pkg.sv
// Shared constants, injection FSM encoding and the highest-bit picker used by
// the deflection router output-port scheduler.
package deflect_alloc_sched_pkg;

    localparam int NUM_IN    = 4;
    localparam int NUM_PORT  = 5;
    localparam int EJECT_BIT = 4;

    localparam logic [NUM_PORT-1:0] CARD_MASK = 5'b01111;
    localparam logic [NUM_PORT-1:0] AVAIL_ALL = 5'b11111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } inj_state_e;

    // One-hot of the highest set bit, zero when nothing is set.
    function automatic logic [NUM_PORT-1:0] top_bit(input logic [NUM_PORT-1:0] v);
        top_bit = '0;
        for (int b = 0; b < NUM_PORT; b++) begin
            if (v[b]) begin
                top_bit    = '0;
                top_bit[b] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/deflect_alloc_sched_alloc_step.sv
// One link of the allocation chain: grant a productive free port if possible,
// otherwise deflect to the highest free cardinal port.
module alloc_step
    import deflect_alloc_sched_pkg::*;
(
    input  logic                req,
    input  logic [NUM_PORT-1:0] ppv,
    input  logic [NUM_PORT-1:0] avail,
    input  logic                allow_eject,
    output logic [NUM_PORT-1:0] grant,
    output logic                deflect,
    output logic [NUM_PORT-1:0] avail_next
);

    logic [NUM_PORT-1:0] reach;
    logic [NUM_PORT-1:0] hit;

    always_comb begin
        reach            = CARD_MASK;
        reach[EJECT_BIT] = allow_eject;
        hit              = ppv & avail & reach;
        grant            = '0;
        deflect          = 1'b0;
        if (req) begin
            if (hit != '0) begin
                grant = top_bit(hit);
            end else begin
                // Eject is never a deflection target.
                grant   = top_bit(avail & CARD_MASK);
                deflect = 1'b1;
            end
        end
        avail_next = avail & ~grant;
    end

endmodule

// File: rtl/deflect_alloc_sched.sv
// Two-stage output-port scheduler: S1 captures flits and ranks them, S2 walks
// the rank order through the allocation chain. Also owns injection and epoch.
module deflect_alloc_sched
    import deflect_alloc_sched_pkg::*;
#(
    parameter int AGE_W     = 8,
    parameter int ID_W      = 4,
    parameter int EPOCH_LEN = 64,
    parameter int STARVE_TH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN*NUM_PORT-1:0]   in_ppv,
    input  logic [NUM_IN*AGE_W-1:0]      in_age,
    input  logic [NUM_IN-1:0]            in_golden,
    input  logic                         inj_req,
    input  logic [NUM_PORT-1:0]          inj_ppv,
    output logic [NUM_IN-1:0]            out_valid,
    output logic [NUM_IN*NUM_PORT-1:0]   out_port,
    output logic [NUM_IN-1:0]            out_deflect,
    output logic                         inj_grant,
    output logic                         inj_fail,
    output logic [NUM_PORT-1:0]          inj_port,
    output logic                         inj_starve,
    output logic [ID_W-1:0]              golden_id
);

    localparam int RANK_W   = $clog2(NUM_IN);
    localparam int CNT_W    = RANK_W + 1;
    localparam int EPOCH_W  = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
    localparam int STARVE_W = $clog2(STARVE_TH + 1);

    logic [NUM_IN-1:0]                 v1_q;
    logic [NUM_PORT-1:0]               ppv1_q   [NUM_IN];
    logic [RANK_W-1:0]                 order1_q [NUM_IN];
    logic [RANK_W-1:0]                 order_d  [NUM_IN];
    logic                              inj1_q;
    logic [NUM_PORT-1:0]               injppv1_q;
    logic [NUM_IN-1:0]                 valid_q, defl_q, defl_d;
    logic [NUM_IN-1:0][NUM_PORT-1:0]   port_q, port_d;
    logic [NUM_PORT-1:0]               inj_port_q;
    logic                              inj_grant_q, inj_fail_q, inj_starve_q;
    logic                              inj_ok_d, inj_fail_d;
    logic [STARVE_W-1:0]               starve_q, starve_d;
    logic [EPOCH_W-1:0]                epoch_q;
    logic [ID_W-1:0]                   golden_q;
    inj_state_e                        state_q;

    logic [CNT_W-1:0]                  cnt_c;
    logic                              beat_c;

    // Rank position of flit i = number of flits that beat it (golden, age, index).
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) order_d[i] = '0;
        cnt_c  = '0;
        beat_c = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_c = '0;
            for (int j = 0; j < NUM_IN; j++) begin
                if (in_golden[j] != in_golden[i])
                    beat_c = in_golden[j];
                else if (in_age[j*AGE_W +: AGE_W] != in_age[i*AGE_W +: AGE_W])
                    beat_c = in_age[j*AGE_W +: AGE_W] > in_age[i*AGE_W +: AGE_W];
                else
                    beat_c = (j < i);
                cnt_c = cnt_c + CNT_W'(beat_c);
            end
            order_d[cnt_c[RANK_W-1:0]] = RANK_W'(i);
        end
    end

    logic [NUM_PORT-1:0] avail_c [NUM_IN+2];
    logic [NUM_PORT-1:0] grant_c [NUM_IN+1];
    logic [NUM_IN:0]     defl_c;
    logic                unused_inj_tail;

    assign avail_c[0] = AVAIL_ALL;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_flit
        alloc_step u_step (
            .req        (v1_q[order1_q[k]]),
            .ppv        (ppv1_q[order1_q[k]]),
            .avail      (avail_c[k]),
            .allow_eject(1'b1),
            .grant      (grant_c[k]),
            .deflect    (defl_c[k]),
            .avail_next (avail_c[k+1])
        );
    end

    // The injected flit only sees what the four arriving flits left behind.
    alloc_step u_inj (
        .req        (inj1_q),
        .ppv        (injppv1_q),
        .avail      (avail_c[NUM_IN]),
        .allow_eject(1'b0),
        .grant      (grant_c[NUM_IN]),
        .deflect    (defl_c[NUM_IN]),
        .avail_next (avail_c[NUM_IN+1])
    );

    assign unused_inj_tail = ^{avail_c[NUM_IN+1], defl_c[NUM_IN]};

    always_comb begin
        port_d = '0;
        defl_d = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            port_d[order1_q[k]] = grant_c[k];
            defl_d[order1_q[k]] = defl_c[k];
        end
    end

    assign inj_ok_d   = inj1_q && (grant_c[NUM_IN] != '0);
    assign inj_fail_d = inj1_q && (grant_c[NUM_IN] == '0);

    always_comb begin
        starve_d = starve_q;
        if (inj_fail_d) begin
            if (starve_q != STARVE_W'(STARVE_TH)) starve_d = starve_q + 1'b1;
        end else if (inj_ok_d || (state_q == IDLE && !inj_req)) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q      <= '0;
            inj1_q    <= 1'b0;
            injppv1_q <= '0;
            valid_q   <= '0;
            port_q    <= '0;
            defl_q    <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                ppv1_q[i]   <= '0;
                order1_q[i] <= '0;
            end
        end else begin
            v1_q      <= in_valid;
            inj1_q    <= (state_q == IDLE) && inj_req;
            injppv1_q <= inj_ppv & CARD_MASK;
            valid_q   <= v1_q;
            port_q    <= port_d;
            defl_q    <= defl_d;
            for (int i = 0; i < NUM_IN; i++) begin
                ppv1_q[i]   <= in_ppv[i*NUM_PORT +: NUM_PORT];
                order1_q[i] <= order_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            inj_grant_q  <= 1'b0;
            inj_fail_q   <= 1'b0;
            inj_port_q   <= '0;
            inj_starve_q <= 1'b0;
            starve_q     <= '0;
            epoch_q      <= '0;
            golden_q     <= '0;
        end else begin
            case (state_q)
                IDLE:    if (inj_req) state_q <= WAIT1;
                WAIT1:   state_q <= WAIT2;
                default: state_q <= IDLE;
            endcase
            inj_grant_q  <= inj_ok_d;
            inj_fail_q   <= inj_fail_d;
            inj_port_q   <= grant_c[NUM_IN];
            starve_q     <= starve_d;
            inj_starve_q <= (starve_d == STARVE_W'(STARVE_TH));
            if (epoch_q == EPOCH_W'(EPOCH_LEN - 1)) begin
                epoch_q  <= '0;
                golden_q <= golden_q + 1'b1;
            end else begin
                epoch_q <= epoch_q + 1'b1;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_port    = port_q;
    assign out_deflect = defl_q;
    assign inj_grant   = inj_grant_q;
    assign inj_fail    = inj_fail_q;
    assign inj_port    = inj_port_q;
    assign inj_starve  = inj_starve_q;
    assign golden_id   = golden_q;

endmodule

// File: tb/tb_deflect_alloc_sched.sv
// Self-checking bench for deflect_alloc_sched: directed scenarios plus random
// traffic, all compared against a sort-and-allocate reference model.
module tb_deflect_alloc_sched;

    localparam int EL = 8;
    localparam int ST = 4;

    typedef struct packed {
        logic [3:0]       v;
        logic [3:0][4:0]  ppv;
        logic [3:0][7:0]  age;
        logic [3:0]       g;
        logic             att;
        logic [4:0]       ippv;
    } cyc_t;

    typedef struct packed {
        logic [3:0]       v;
        logic [3:0][4:0]  port;
        logic [3:0]       defl;
        logic             grant;
        logic             fail;
        logic [4:0]       iport;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [19:0] in_ppv;
    logic [31:0] in_age;
    logic [3:0]  in_golden;
    logic        inj_req;
    logic [4:0]  inj_ppv;
    logic [3:0]  out_valid;
    logic [19:0] out_port;
    logic [3:0]  out_deflect;
    logic        inj_grant;
    logic        inj_fail;
    logic [4:0]  inj_port;
    logic        inj_starve;
    logic [1:0]  golden_id;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int free_at = 0;
    int edges = 0;
    int cnt = 0;
    exp_t exp_q[$];

    deflect_alloc_sched #(
        .AGE_W(8), .ID_W(2), .EPOCH_LEN(EL), .STARVE_TH(ST)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ppv(in_ppv), .in_age(in_age), .in_golden(in_golden),
        .inj_req(inj_req), .inj_ppv(inj_ppv),
        .out_valid(out_valid), .out_port(out_port), .out_deflect(out_deflect),
        .inj_grant(inj_grant), .inj_fail(inj_fail), .inj_port(inj_port),
        .inj_starve(inj_starve), .golden_id(golden_id)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [4:0] top_of(input logic [4:0] v);
        for (int b = 4; b >= 0; b--) if (v[b]) return 5'(1 << b);
        return 5'b0;
    endfunction

    function automatic bit beats(input cyc_t c, input int x, input int y);
        if (c.g[x] != c.g[y]) return c.g[x];
        if (c.age[x] != c.age[y]) return c.age[x] > c.age[y];
        return x < y;
    endfunction

    // Sort flits best-first, then hand out ports in that order.
    function automatic exp_t model(input cyc_t c);
        exp_t e;
        int ord[4];
        int t;
        logic [4:0] avail, hit, pick;
        e = '0;
        e.v = c.v;
        for (int i = 0; i < 4; i++) ord[i] = i;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                if (beats(c, ord[b+1], ord[b])) begin
                    t = ord[b]; ord[b] = ord[b+1]; ord[b+1] = t;
                end
        avail = 5'b11111;
        for (int r = 0; r < 4; r++) begin
            t = ord[r];
            if (c.v[t]) begin
                hit = c.ppv[t] & avail;
                if (hit != 0) begin
                    pick = top_of(hit);
                end else begin
                    pick = top_of(avail & 5'b01111);
                    e.defl[t] = 1'b1;
                end
                e.port[t] = pick;
                avail = avail & ~pick;
            end
        end
        if (c.att) begin
            hit  = c.ippv & avail & 5'b01111;
            pick = (hit != 0) ? top_of(hit) : top_of(avail & 5'b01111);
            if (pick != 0) begin
                e.grant = 1'b1;
                e.iport = pick;
            end else begin
                e.fail = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back('0);
        cnt = 0;
        free_at = cyc;
        edges = 0;
    endtask

    task automatic clear_in();
        in_valid = '0; in_ppv = '0; in_age = '0; in_golden = '0;
    endtask

    task automatic set_flit(input int i, input logic [4:0] ppv, input logic [7:0] age, input logic g);
        in_valid[i] = 1'b1;
        in_ppv[i*5 +: 5] = ppv;
        in_age[i*8 +: 8] = age;
        in_golden[i] = g;
    endtask

    // Advance one clock with the currently driven inputs and score the outputs.
    task automatic step();
        cyc_t cur;
        exp_t e;
        logic idle, req;
        cur.v = in_valid; cur.ppv = in_ppv; cur.age = in_age; cur.g = in_golden;
        cur.ippv = inj_ppv;
        req  = inj_req;
        idle = (cyc >= free_at);
        cur.att = req && idle;
        if (cur.att) free_at = cyc + 3;
        exp_q.push_back(model(cur));
        @(posedge clk); #1;
        cyc++;
        edges++;
        e = exp_q.pop_front();
        if (e.fail) begin
            if (cnt < ST) cnt++;
        end else if (e.grant || (idle && !req)) begin
            cnt = 0;
        end
        check_val("out_valid", out_valid, e.v);
        check_val("out_port", out_port, e.port);
        check_val("out_deflect", out_deflect, e.defl);
        check_val("inj_grant", inj_grant, e.grant);
        check_val("inj_fail", inj_fail, e.fail);
        check_val("inj_port", inj_port, e.iport);
        check_val("inj_starve", inj_starve, (cnt == ST));
        check_val("golden_id", golden_id, (edges / EL) % 4);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, out_valid, 0);
        check_val({tag, "_port"}, out_port, 0);
        check_val({tag, "_defl"}, out_deflect, 0);
        check_val({tag, "_inj"}, {inj_grant, inj_fail, inj_port, inj_starve}, 0);
        check_val({tag, "_gold"}, golden_id, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit pending;
        reset = 1'b1;
        clear_in();
        inj_req = 1'b0;
        inj_ppv = '0;
        #1;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Single flit.
        clear_in(); set_flit(0, 5'b00011, 8'd5, 1'b0); step();
        clear_in(); step();
        check_val("single_port0", out_port[4:0], 5'b00010);
        check_val("single_others", out_port[19:5], 0);
        check_val("single_defl", out_deflect, 0);

        // Age contention.
        clear_in(); set_flit(0, 5'b00001, 8'd3, 1'b0); set_flit(1, 5'b00001, 8'd7, 1'b0); step();
        clear_in(); step();
        check_val("contend_in1", out_port[9:5], 5'b00001);
        check_val("contend_in0", out_port[4:0], 5'b01000);
        check_val("contend_defl", out_deflect, 4'b0001);

        // Golden beats age.
        clear_in(); set_flit(2, 5'b00100, 8'd0, 1'b1); set_flit(3, 5'b00100, 8'd9, 1'b0); step();
        clear_in(); step();
        check_val("golden_in2", out_port[14:10], 5'b00100);
        check_val("golden_in3", out_port[19:15], 5'b01000);
        check_val("golden_defl", out_deflect, 4'b1000);

        // Eject conflict.
        clear_in(); set_flit(0, 5'b10000, 8'd2, 1'b0); set_flit(1, 5'b10000, 8'd6, 1'b0); step();
        clear_in(); step();
        check_val("eject_in1", out_port[9:5], 5'b10000);
        check_val("eject_in0", out_port[4:0], 5'b01000);
        check_val("eject_defl", out_deflect, 4'b0001);

        // Starvation: four flits fill every cardinal port.
        inj_ppv = 5'b00001;
        inj_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            clear_in();
            for (int i = 0; i < 4; i++) set_flit(i, 5'b01000, 8'($urandom_range(0, 255)), 1'b0);
            step();
            if (c % 3 == 2) check_val("starve_fail_pulse", inj_fail, 1);
            if (c == 8) check_val("starve_not_yet", inj_starve, 0);
            if (c == 11) check_val("starve_raised", inj_starve, 1);
        end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            clear_in();
            for (int i = 0; i < 3; i++) set_flit(i, 5'b01000, 8'($urandom_range(0, 255)), 1'b0);
            step();
            if (inj_grant) begin
                got = 1'b1;
                check_val("recover_port", inj_port, 5'b00001);
                check_val("recover_starve", inj_starve, 0);
            end
        end
        check_val("recover_seen", got, 1);
        inj_req = 1'b0;

        // Reset while an injection attempt sits in WAIT1.
        clear_in(); set_flit(0, 5'b00010, 8'd1, 1'b0);
        inj_req = 1'b1; inj_ppv = 5'b00010;
        step();
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        inj_req = 1'b0;
        clear_in();
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Golden epoch stepping and wrap.
        for (int c = 1; c <= 33; c++) begin
            step();
            if (c == 2) check_val("midreset_no_grant", inj_grant, 0);
            if (c == 7) check_val("epoch_before", golden_id, 0);
            if (c == 8) check_val("epoch_step1", golden_id, 1);
            if (c == 31) check_val("epoch_last", golden_id, 3);
            if (c == 32) check_val("epoch_wrap", golden_id, 0);
        end

        // Random traffic with a well-behaved injection requester.
        pending = 1'b0;
        for (int n = 0; n < 400; n++) begin
            clear_in();
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) != 0)
                    set_flit(i, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 7)),
                             ($urandom_range(0, 7) == 0));
            if (!pending && $urandom_range(0, 2) == 0) begin
                pending = 1'b1;
                inj_ppv = 5'($urandom_range(0, 31));
            end
            inj_req = pending;
            step();
            if (inj_grant) pending = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
